// File: rtl/alu_opcodes_pkg.sv
// ALU opcode encoding shared by the decode stage and the ALU.
package alu_opcodes_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'b00000;
  localparam alu_op_t ALU_SUB  = 5'b01000;
  localparam alu_op_t ALU_SLL  = 5'b00001;
  localparam alu_op_t ALU_SLTS = 5'b00010;
  localparam alu_op_t ALU_SLTU = 5'b00011;
  localparam alu_op_t ALU_XOR  = 5'b00100;
  localparam alu_op_t ALU_SRL  = 5'b00101;
  localparam alu_op_t ALU_SRA  = 5'b01101;
  localparam alu_op_t ALU_OR   = 5'b00110;
  localparam alu_op_t ALU_AND  = 5'b00111;
  localparam alu_op_t ALU_EQ   = 5'b11000;
  localparam alu_op_t ALU_NE   = 5'b11001;
  localparam alu_op_t ALU_LTS  = 5'b11100;
  localparam alu_op_t ALU_GES  = 5'b11101;
  localparam alu_op_t ALU_LTU  = 5'b11110;
  localparam alu_op_t ALU_GEU  = 5'b11111;

endpackage

// File: rtl/riscv_pkg.sv
// RV32I opcode constants, decode control bundle and immediate helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // Source of ALU operand a.
  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_e;

  // Source of ALU operand b.
  typedef enum logic {
    B_RS2 = 1'b0,
    B_IMM = 1'b1
  } b_sel_e;

  typedef struct packed {
    logic rd_we;
    logic branch;
    logic jump;
    logic mem_req;
    logic mem_we;
    logic illegal;
  } id_ctrl_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Pure combinational RV32I decoder: instruction -> operand selects,
// immediate, ALU opcode and control flags.
module id_decoder
  import riscv_pkg::*;
  import alu_opcodes_pkg::*;
(
  input  logic [31:0] i_instr,
  output a_sel_e      o_a_sel,
  output b_sel_e      o_b_sel,
  output logic [31:0] o_imm,
  output alu_op_t     o_alu_op,
  output id_ctrl_t    o_ctrl
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_rd     = i_instr[11:7];

  // Decode opcode/funct fields; illegal encodings collapse to a harmless ADD 0,0.
  always_comb begin
    logic w_legal;
    // NOTE: every output gets a default first so no path can infer a latch.
    o_a_sel  = A_RS1;
    o_b_sel  = B_RS2;
    o_imm    = '0;
    o_alu_op = ALU_ADD;
    o_ctrl   = '0;
    w_legal  = 1'b1;

    case (w_opcode)
      OPC_OP: begin
        o_ctrl.rd_we = 1'b1;
        if (w_funct7 == FUNCT7_BASE) begin
          o_alu_op = {2'b00, w_funct3};
        end else if (w_funct7 == FUNCT7_ALT &&
                     (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          o_alu_op = {2'b01, w_funct3};
        end else begin
          w_legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        o_b_sel      = B_IMM;
        o_imm        = imm_i(i_instr);
        o_alu_op     = {2'b00, w_funct3};
        o_ctrl.rd_we = 1'b1;
        if (w_funct3 == 3'b001 && w_funct7 != FUNCT7_BASE) begin
          w_legal = 1'b0;
        end
        if (w_funct3 == 3'b101) begin
          // Shifts take only the 5-bit shamt; funct7 selects logical/arith.
          o_imm = {27'b0, i_instr[24:20]};
          if (w_funct7 == FUNCT7_ALT) begin
            o_alu_op = ALU_SRA;
          end else if (w_funct7 != FUNCT7_BASE) begin
            w_legal = 1'b0;
          end
        end
      end
      OPC_LUI: begin
        o_a_sel      = A_ZERO;
        o_b_sel      = B_IMM;
        o_imm        = imm_u(i_instr);
        o_ctrl.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        o_a_sel      = A_PC;
        o_b_sel      = B_IMM;
        o_imm        = imm_u(i_instr);
        o_ctrl.rd_we = 1'b1;
      end
      OPC_BRANCH: begin
        o_alu_op      = {2'b11, w_funct3};
        o_ctrl.branch = 1'b1;
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        o_b_sel        = B_IMM;
        o_imm          = imm_i(i_instr);
        o_ctrl.mem_req = 1'b1;
        o_ctrl.rd_we   = 1'b1;
      end
      OPC_STORE: begin
        o_b_sel        = B_IMM;
        o_imm          = imm_s(i_instr);
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes the link address pc+4.
        o_a_sel      = A_PC;
        o_b_sel      = B_IMM;
        o_imm        = 32'd4;
        o_ctrl.jump  = 1'b1;
        o_ctrl.rd_we = 1'b1;
        if (w_opcode == OPC_JALR && w_funct3 != 3'b000) begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      o_a_sel        = A_ZERO;
      o_b_sel        = B_IMM;
      o_imm          = '0;
      o_alu_op       = ALU_ADD;
      o_ctrl         = '0;
      o_ctrl.illegal = 1'b1;
    end

    // Writes to x0 are architecturally discarded.
    if (w_rd == 5'd0) begin
      o_ctrl.rd_we = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register-file address generation, operand muxing and
// a single valid/ready pipeline register with flush.
module id_stage
  import riscv_pkg::*;
  import alu_opcodes_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [4:0]      alu_op_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  a_sel_e          w_a_sel;
  b_sel_e          w_b_sel;
  logic [31:0]     w_imm;
  alu_op_t         w_alu_op;
  id_ctrl_t        w_ctrl;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  alu_op_t         r_alu_op;
  logic [XLEN-1:0] r_store_data;
  logic [4:0]      r_rd_addr;
  id_ctrl_t        r_ctrl;
  logic [XLEN-1:0] r_pc;

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  id_decoder u_decoder (
    .i_instr  (instr_i),
    .o_a_sel  (w_a_sel),
    .o_b_sel  (w_b_sel),
    .o_imm    (w_imm),
    .o_alu_op (w_alu_op),
    .o_ctrl   (w_ctrl)
  );

  // Operand a source select.
  always_comb begin
    case (w_a_sel)
      A_RS1:   w_a = rs1_data_i;
      A_PC:    w_a = pc_i;
      default: w_a = '0;
    endcase
  end

  // Operand b source select.
  always_comb begin
    w_b = (w_b_sel == B_IMM) ? w_imm : rs2_data_i;
  end

  // Flush makes the stage ready so the presented beat is consumed and dropped.
  assign in_ready_o = !r_valid || out_ready_i || flush_i;
  assign w_accept   = in_valid_i && in_ready_o;

  // Pipeline register: flush wins, then accept, then downstream drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: data registers are reset too so every output is defined out of reset.
      r_valid      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_op     <= ALU_ADD;
      r_store_data <= '0;
      r_rd_addr    <= '0;
      r_ctrl       <= '0;
      r_pc         <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_accept && !flush_i) begin
        r_a          <= w_a;
        r_b          <= w_b;
        r_alu_op     <= w_alu_op;
        r_store_data <= rs2_data_i;
        r_rd_addr    <= instr_i[11:7];
        r_ctrl       <= w_ctrl;
        r_pc         <= pc_i;
      end
    end
  end

  assign out_valid_o  = r_valid;
  assign a_o          = r_a;
  assign b_o          = r_b;
  assign alu_op_o     = r_alu_op;
  assign store_data_o = r_store_data;
  assign rd_addr_o    = r_rd_addr;
  assign rd_we_o      = r_ctrl.rd_we;
  assign branch_o     = r_ctrl.branch;
  assign jump_o       = r_ctrl.jump;
  assign mem_req_o    = r_ctrl.mem_req;
  assign mem_we_o     = r_ctrl.mem_we;
  assign illegal_o    = r_ctrl.illegal;
  assign pc_o         = r_pc;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the RV32I core; the producer side of the ALU operand/opcode interface.
- Accepts a fetched instruction and PC over a valid/ready handshake and decodes it into ALU operands, a 5-bit alu_op and writeback/control fields.
- Presents these through one registered pipeline stage with valid/ready, stall and flush.
- Register-file read addresses are combinational from the input; read data returns combinationally in the same cycle.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value of pc_o while invalid after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- in_valid_i  in  1  instr_i/pc_i hold a valid beat.
- in_ready_o  out  1  stage can accept a beat this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  32  instruction address.
- rs1_addr_o  out  5  comb, instr_i[19:15].
- rs2_addr_o  out  5  comb, instr_i[24:20].
- rs1_data_i  in  32  register-file read data for rs1.
- rs2_data_i  in  32  register-file read data for rs2.
- flush_i  in  1  kill the registered beat and the beat currently presented.
- out_valid_o  out  1  registered outputs hold a valid beat.
- out_ready_i  in  1  downstream consumes the beat.
- a_o  out  32  ALU operand a.
- b_o  out  32  ALU operand b.
- alu_op_o  out  5  ALU opcode.
- store_data_o  out  32  rs2 data, for STORE.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  register writeback enable.
- branch_o  out  1  conditional branch.
- jump_o  out  1  JAL or JALR.
- mem_req_o  out  1  LOAD or STORE.
- mem_we_o  out  1  STORE.
- illegal_o  out  1  unsupported encoding.
- pc_o  out  32  PC of the beat.

Behaviour:
Reset and latency:
- Reset (rst_ni=0, asynchronous): out_valid_o=0; all registered outputs 0, except pc_o=RESET_PC.
- Latency: 1 cycle from accepted input to out_valid_o.

Handshake:
- in_ready_o = !out_valid_o || out_ready_i || flush_i.
- Accept = in_valid_i && in_ready_o.
- On accept without flush: the output register loads the decoded beat and out_valid_o=1.
- If out_ready_i=1 and no accept: out_valid_o clears next cycle.
- While out_valid_o=1 and out_ready_i=0: all outputs hold stable. The upstream beat must be held by upstream; it is not lost.

Flush:
- flush_i=1 has priority: the next cycle out_valid_o=0.
- The presented beat counts as consumed and is discarded.
- The data registers may keep their old values.

Decode (opcode instr[6:0]; alu_op encoding as defined in alu_opcodes_pkg: ADD 00000, SUB 01000, SLL 00001, SLTS 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, EQ 11000, NE 11001, LTS 11100, GES 11101, LTU 11110, GEU 11111):
- OP 0110011: a=rs1, b=rs2.
  - funct7=0x00: op={2'b00,funct3}.
  - funct7=0x20 with funct3 000 or 101: op={2'b01,funct3}.
  - Otherwise illegal.
  - rd_we=1.
- OP-IMM 0010011: a=rs1, b=sext I-imm, op={2'b00,funct3}, rd_we=1.
  - funct3 001 requires funct7=0x00.
  - funct3 101 requires funct7 0x00 (SRL) or 0x20 (SRA → 01101); b=shamt zero-extended.
- LUI 0110111: a=0, b={instr[31:12],12'b0}, ADD, rd_we=1.
- AUIPC 0010111: a=pc, b=U-imm, ADD, rd_we=1.
- BRANCH 1100011: a=rs1, b=rs2, op={2'b11,funct3}, branch=1, rd_we=0. funct3 010 and 011 are illegal.
- LOAD 0000011: a=rs1, b=I-imm, ADD, mem_req=1, rd_we=1.
- STORE 0100011: a=rs1, b=sext S-imm, ADD, mem_req=1, mem_we=1, rd_we=0.
- JAL 1101111 / JALR 1100111: a=pc, b=4, ADD, jump=1, rd_we=1. JALR requires funct3=000.
- Any other opcode, or an illegal combination above: illegal_o=1 with a=b=0, op=ADD and all enables/flags 0.
- rd_we_o is forced to 0 when rd=0.

Decomposition:
- Reuse alu_opcodes_pkg for the alu_op constants.
- Add riscv_pkg holding opcode constants and an id_ctrl_t struct (rd_we, branch, jump, mem_req, mem_we, illegal).
- One sub-module, id_decoder: pure combinational instruction → {a_sel, b_sel, imm, alu_op, id_ctrl_t}.
- id_stage owns operand muxing, the handshake and the pipeline register.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7 → next cycle: out_valid=1, a=5, b=7, op=00000, rd=3, rd_we=1.
- SRAI x5,x6,4 (0x40435293) with rs1=0x8000_0000 → a=0x8000_0000, b=4, op=01101, illegal=0.
- BGEU x1,x2 (0x0020F063) → op=11111, branch=1, rd_we=0; funct3=010 variant → illegal=1, op=00000.
- Back-pressure: out_ready=0 for 3 cycles with new input pending → in_ready=0, outputs stable; out_ready=1 → the pending beat loads the next cycle, none dropped.
- flush_i pulse while out_valid=1 and in_valid=1 → next cycle out_valid=0, presented beat not emitted.
- rst_ni asserted mid-stream (asynchronously) → out_valid=0 immediately and pc_o=RESET_PC; ADDI x0,x0,1 (0x00100013) → rd_we=0.
